// File: rtl/round_key_buffer.sv
// AES-256 round-key buffer: drives the key-expansion stage and stores the 15 round keys it returns.
// Optional macro RKB_REV_READ_EN enables reverse-order (decryption) reads via rk_rev_i.
module round_key_buffer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [255:0] key_i,
    output logic [255:0] exp_key_o,
    output logic [3:0]   exp_round_o,
    input  logic [127:0] exp_key_i,
    input  logic         rk_req_i,
    input  logic [3:0]   rk_idx_i,
    input  logic         rk_rev_i,
    output logic [127:0] rk_o,
    output logic         rk_valid_o,
    output logic         rk_err_o,
    output logic         ready_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DRAIN  = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   counter;
    logic         cap_en;
    logic [3:0]   cap_idx;
    logic [3:0]   eff_idx;
    logic         accept;
    logic         read_ok;
    logic [127:0] slots [15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, READY: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (counter == 4'd14) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = READY;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The expansion stage answers one cycle late, so the write index trails the round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= 4'd0;
            exp_key_o <= 256'd0;
            cap_en    <= 1'b0;
            cap_idx   <= 4'd0;
        end else begin
            cap_en  <= (state == EXPAND);
            cap_idx <= counter;
            if (accept) begin
                exp_key_o <= key_i;
                counter   <= 4'd0;
            end else if (state == EXPAND && counter != 4'd14) begin
                counter <= counter + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            slots[cap_idx] <= exp_key_i;
        end
    end

`ifdef RKB_REV_READ_EN
    assign eff_idx = rk_rev_i ? (4'd14 - rk_idx_i) : rk_idx_i;
`else
    logic unused_rev;
    assign unused_rev = rk_rev_i;
    assign eff_idx    = rk_idx_i;
`endif

    // A start in the same cycle wins over a read, so the read is rejected.
    assign read_ok = (state == READY) && !start_i && (rk_idx_i <= 4'd14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_o       <= 128'd0;
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
        end else begin
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
            if (rk_req_i) begin
                if (read_ok) begin
                    rk_o       <= slots[eff_idx];
                    rk_valid_o <= 1'b1;
                end else begin
                    rk_err_o <= 1'b1;
                end
            end
        end
    end

    assign exp_round_o = (state == EXPAND) ? counter : 4'd0;
    assign busy_o      = (state == EXPAND) || (state == DRAIN);
    assign ready_o     = (state == READY);

endmodule

// File: tb/tb_round_key_buffer.sv
// Scoreboard testbench for round_key_buffer; reads are queued as expectations and checked by a monitor.
// Expected reverse-read result follows RKB_REV_READ_EN when the bench is built with it.
module tb_round_key_buffer;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [255:0] key_i;
    logic [255:0] exp_key_o;
    logic [3:0]   exp_round_o;
    logic [127:0] exp_key_i;
    logic         rk_req_i;
    logic [3:0]   rk_idx_i;
    logic         rk_rev_i;
    logic [127:0] rk_o;
    logic         rk_valid_o;
    logic         rk_err_o;
    logic         ready_o;
    logic         busy_o;

    typedef struct {
        logic         is_err;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] last_rk  = 128'd0;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] RK0  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] RK14 = 128'h24FC79CCBF0979E9371AC23C6D68DE36;

    round_key_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .key_i       (key_i),
        .exp_key_o   (exp_key_o),
        .exp_round_o (exp_round_o),
        .exp_key_i   (exp_key_i),
        .rk_req_i    (rk_req_i),
        .rk_idx_i    (rk_idx_i),
        .rk_rev_i    (rk_rev_i),
        .rk_o        (rk_o),
        .rk_valid_o  (rk_valid_o),
        .rk_err_o    (rk_err_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS-197 values for rounds 0, 1 and 14; distinctive filler for the rest.
    function automatic logic [127:0] round_key(input int r);
        logic [31:0] rr;
        rr = 32'(r);
        case (r)
            0:       return RK0;
            1:       return 128'h101112131415161718191A1B1C1D1E1F;
            14:      return RK14;
            default: return {32'hC0DE0000 + rr, 32'h12340000 + rr, ~rr, 32'h0BAD0000 + rr};
        endcase
    endfunction

    // Model of the key-expansion stage: one cycle of latency.
    always @(posedge clk) begin
        exp_key_i <= round_key(int'(exp_round_o));
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read for one cycle and queue the expected response.
    task automatic issueRead(input logic [3:0] idx, input logic rev, input logic is_err, input logic [127:0] data);
        exp_t e;
        rk_req_i = 1'b1;
        rk_idx_i = idx;
        rk_rev_i = rev;
        e.is_err = is_err;
        e.data   = is_err ? last_rk : data;
        if (!is_err) last_rk = data;
        sb.push_back(e);
        tick();
        rk_req_i = 1'b0;
        rk_rev_i = 1'b0;
    endtask

    // One expansion sequence; optionally a read alongside start, and a stray start plus read at cycle 5.
    task automatic applyStimulus(input logic [255:0] key, input logic read_with_start, input logic inject_at5);
        exp_t e;
        start_i = 1'b1;
        key_i   = key;
        if (read_with_start) begin
            rk_req_i = 1'b1;
            rk_idx_i = 4'd2;
            e.is_err = 1'b1;
            e.data   = last_rk;
            sb.push_back(e);
        end
        for (int c = 1; c <= 17; c++) begin
            tick();
            start_i  = 1'b0;
            rk_req_i = 1'b0;
            key_i    = ~key;
            if (c == 5 && inject_at5) begin
                start_i  = 1'b1;
                rk_req_i = 1'b1;
                rk_idx_i = 4'd3;
                e.is_err = 1'b1;
                e.data   = last_rk;
                sb.push_back(e);
            end
            if (c <= 15) begin
                checkOutput($sformatf("exp_round_c%0d", c), 256'(exp_round_o), 256'(c - 1));
                checkOutput($sformatf("busy_c%0d", c), 256'(busy_o), 256'(1'b1));
            end else if (c == 16) begin
                checkOutput("ready_c16", 256'(ready_o), 256'(1'b0));
                checkOutput("exp_round_drain", 256'(exp_round_o), 256'(0));
            end else begin
                checkOutput("ready_c17", 256'(ready_o), 256'(1'b1));
                checkOutput("busy_c17", 256'(busy_o), 256'(1'b0));
                checkOutput("exp_key", exp_key_o, key);
            end
        end
    endtask

    // Monitor: every valid/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (rk_valid_o || rk_err_o)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_read_response valid=%0b err=%0b rk=%0h", rk_valid_o, rk_err_o, rk_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rk_err_o !== e.is_err || rk_valid_o !== !e.is_err || rk_o !== e.data) begin
                    failures++;
                    $display("[TB] FAIL read_response valid=%0b err=%0b rk=%0h required err=%0b rk=%0h",
                             rk_valid_o, rk_err_o, rk_o, e.is_err, e.data);
                end
            end
        end
    end

    initial begin
        logic ready_seen;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        key_i    = '0;
        rk_req_i = 1'b0;
        rk_idx_i = 4'd0;
        rk_rev_i = 1'b0;
        #1;
        checkOutput("reset_ready", 256'(ready_o), 256'(0));
        checkOutput("reset_busy", 256'(busy_o), 256'(0));
        checkOutput("reset_rk", 256'(rk_o), 256'(0));
        checkOutput("reset_pulses", 256'({rk_valid_o, rk_err_o}), 256'(0));
        checkOutput("reset_exp_key", exp_key_o, 256'(0));
        checkOutput("reset_exp_round", 256'(exp_round_o), 256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Read before any expansion is rejected.
        issueRead(4'd0, 1'b0, 1'b1, 128'd0);

        applyStimulus(FIPS_KEY, 1'b0, 1'b0);
        issueRead(4'd0, 1'b0, 1'b0, RK0);
        issueRead(4'd14, 1'b0, 1'b0, RK14);
        issueRead(4'd5, 1'b0, 1'b0, round_key(5));
        tick();
`ifdef RKB_REV_READ_EN
        issueRead(4'd0, 1'b1, 1'b0, RK14);
        issueRead(4'd13, 1'b1, 1'b0, round_key(1));
`else
        issueRead(4'd0, 1'b1, 1'b0, RK0);
        issueRead(4'd13, 1'b1, 1'b0, round_key(13));
`endif
        issueRead(4'd15, 1'b0, 1'b1, 128'd0);

        // Start with simultaneous read, stray start and read at cycle 5.
        applyStimulus(~FIPS_KEY, 1'b1, 1'b1);
        issueRead(4'd1, 1'b0, 1'b0, round_key(1));

        // Reset at cycle 8 of a new expansion abandons it.
        start_i = 1'b1;
        key_i   = FIPS_KEY;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 256'(busy_o), 256'(0));
        checkOutput("midreset_ready", 256'(ready_o), 256'(0));
        checkOutput("midreset_exp_round", 256'(exp_round_o), 256'(0));
        checkOutput("midreset_exp_key", exp_key_o, 256'(0));
        checkOutput("midreset_rk", 256'(rk_o), 256'(0));
        last_rk = 128'd0;
        tick();
        rst_n = 1'b1;
        ready_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ready_o || busy_o) ready_seen = 1'b1;
        end
        checkOutput("idle_after_reset", 256'(ready_seen), 256'(0));

        applyStimulus(FIPS_KEY, 1'b0, 1'b0);
        issueRead(4'd14, 1'b0, 1'b0, RK14);

        repeat (3) tick();
        checkOutput("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_key_buffer.md
ROUND_KEY_BUFFER -- requirements
Module: round_key_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  single-cycle request to expand key_i; sampled only in IDLE or READY.
REQ-005 key_i  input  256  AES-256 cipher key, sampled on the accepted start_i edge.
REQ-006 exp_key_o  output  256  registered key driven to the key-expansion stage.
REQ-007 exp_round_o  output  4  round index driven to the key-expansion stage.
REQ-008 exp_key_i  input  128  round key returned by the key-expansion stage.
REQ-009 rk_req_i  input  1  consumer read request; honoured only in READY.
REQ-010 rk_idx_i  input  4  requested round index, 0..14.
REQ-011 rk_rev_i  input  1  reverse-order read (decryption) select.
REQ-012 rk_o  output  128  registered round key read data.
REQ-013 rk_valid_o  output  1  one-cycle pulse qualifying rk_o.
REQ-014 rk_err_o  output  1  one-cycle pulse for a rejected read.
REQ-015 ready_o  output  1  all 15 round keys are stored and readable.
REQ-016 busy_o  output  1  expansion sequence in progress.

Function
REQ-017 The FSM SHALL have states IDLE, EXPAND, DRAIN, READY.
REQ-018 IDLE/READY + start_i -> EXPAND; exp_key_o<=key_i; round counter<=0; ready_o deasserted on the same edge.
REQ-019 In EXPAND, exp_round_o SHALL equal the counter, incrementing by 1 per cycle through 0..14; at 14 the next state is DRAIN.
REQ-020 exp_key_i SHALL be captured into slot r on the edge ending the cycle after exp_round_o = r (one-cycle expansion latency); the capture index is the counter delayed one cycle.
REQ-021 DRAIN SHALL last one cycle (capturing slot 14), then go to READY; start_i at accept cycle 0 gives ready_o = 1 in cycle 17.
REQ-022 Outside EXPAND, exp_round_o SHALL be 0.
REQ-023 start_i in EXPAND or DRAIN SHALL be ignored.
REQ-024 Storage: 15 x 128-bit slots; no slot is readable until all 15 are written.
REQ-025 Read in READY with rk_req_i = 1 and rk_idx_i <= 14: next cycle rk_o = slot[eff_idx], rk_valid_o = 1; eff_idx = rk_idx_i, or 14 - rk_idx_i when rk_rev_i = 1 (see REQ-031).
REQ-026 rk_req_i with rk_idx_i > 14, or rk_req_i outside READY: next cycle rk_err_o = 1, rk_valid_o = 0, rk_o unchanged.
REQ-027 Simultaneous start_i and rk_req_i in READY: start wins; read is rejected per REQ-026.
REQ-028 busy_o = 1 in EXPAND and DRAIN only; ready_o = 1 in READY only.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE; counter 0; exp_round_o 0; exp_key_o 0; rk_o 0; rk_valid_o, rk_err_o, ready_o, busy_o 0; slot contents need not be cleared.
REQ-030 Reset mid-EXPAND SHALL abandon the sequence; a new start_i is required before ready_o reasserts.

Configuration
REQ-031 Macro RKB_REV_READ_EN: defined -> rk_rev_i honoured per REQ-025; undefined -> rk_rev_i ignored, eff_idx = rk_idx_i, no subtractor synthesised.

Verification
REQ-032 FIPS-197 key 000102..1F, start_i pulse -> ready_o high at cycle 17; exp_round_o seen as 0..14 in cycles 1..15.
REQ-033 After REQ-032, read idx 0 -> rk_o = 000102030405060708090A0B0C0D0E0F; idx 14 -> 24FC79CCBF0979E9371AC23C6D68DE36; rk_valid_o one cycle each.
REQ-034 With RKB_REV_READ_EN, rk_rev_i = 1, idx 0 -> key of round 14 (24FC79CC...); without macro -> round 0 key.
REQ-035 Read idx 15 in READY, and any read in EXPAND -> rk_err_o pulse, rk_valid_o 0, rk_o unchanged.
REQ-036 start_i at cycle 5 of EXPAND -> ignored, ready_o at cycle 17; rst_n low at cycle 8 -> all outputs 0, state IDLE, ready_o stays 0 until a new 17-cycle sequence completes.
